// File: rtl/keccak_pkg.sv
// Shared Keccak absorb definitions: bus widths, mode and state enums, padding bytes.
package keccak_pkg;
  localparam int MAX_INPUT_DWIDTH = 256;
  localparam int MAX_RATE_BYTES   = 168;
  localparam int KEEP_WIDTH       = MAX_INPUT_DWIDTH / 8;
  localparam int MODE_SEL_WIDTH   = 2;
  localparam int RATE_WIDTH       = 11;
  localparam int FILL_WIDTH       = 8;
  localparam int BOFF_WIDTH       = 6;

  typedef enum logic [MODE_SEL_WIDTH-1:0] {
    SHA3_256 = 2'd0,
    SHA3_512 = 2'd1,
    SHAKE128 = 2'd2,
    SHAKE256 = 2'd3
  } keccak_mode_e;

  typedef enum logic [1:0] {IDLE, ABSORB, PAD, FLUSH} absorb_state_e;

  localparam logic [7:0] DS_SHA3  = 8'h06;
  localparam logic [7:0] DS_SHAKE = 8'h1F;
  localparam logic [7:0] PAD_END  = 8'h80;

  function automatic logic [BOFF_WIDTH-1:0] keep_popcount(input logic [KEEP_WIDTH-1:0] keep);
    logic [BOFF_WIDTH-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      cnt = cnt + {{(BOFF_WIDTH-1){1'b0}}, keep[i]};
    end
    return cnt;
  endfunction

  function automatic logic [7:0] domain_suffix(input keccak_mode_e mode);
    return (mode == SHAKE128 || mode == SHAKE256) ? DS_SHAKE : DS_SHA3;
  endfunction
endpackage

// File: rtl/absorb_unit_if.sv
// Message-beat input stream and rate-block output stream of the absorb unit.
interface absorb_unit_if;
  import keccak_pkg::*;

  logic [MAX_INPUT_DWIDTH-1:0] t_data_i;
  logic [KEEP_WIDTH-1:0]       t_keep_i;
  logic                        t_last_i;
  logic                        t_valid_i;
  logic                        t_ready_o;
  logic [MAX_RATE_BYTES*8-1:0] block_o;
  logic                        block_valid_o;
  logic                        block_ready_i;
  logic                        block_last_o;

  modport slave (
    input  t_data_i, t_keep_i, t_last_i, t_valid_i, block_ready_i,
    output t_ready_o, block_o, block_valid_o, block_last_o
  );

  modport master (
    output t_data_i, t_keep_i, t_last_i, t_valid_i, block_ready_i,
    input  t_ready_o, block_o, block_valid_o, block_last_o
  );
endinterface

// File: rtl/byte_packer.sv
// Merges i_n beat bytes starting at i_beat_off into the block buffer at byte offset i_fill.
module byte_packer
  import keccak_pkg::*;
(
  input  logic [MAX_RATE_BYTES*8-1:0] i_block,
  input  logic [MAX_INPUT_DWIDTH-1:0] i_data,
  input  logic [BOFF_WIDTH-1:0]       i_beat_off,
  input  logic [FILL_WIDTH-1:0]       i_fill,
  input  logic [BOFF_WIDTH-1:0]       i_n,
  output logic [MAX_RATE_BYTES*8-1:0] o_block
);
  localparam int BLK_W = MAX_RATE_BYTES * 8;

  logic [BLK_W-1:0]          w_src;
  logic [MAX_RATE_BYTES-1:0] w_mask;

  // Align the untaken part of the beat to byte 0, then move it up to the fill point.
  assign w_src  = {{(BLK_W-MAX_INPUT_DWIDTH){1'b0}}, i_data >> {i_beat_off, 3'b000}}
                  << {i_fill, 3'b000};
  assign w_mask = ((MAX_RATE_BYTES'(1) << i_n) - MAX_RATE_BYTES'(1)) << i_fill;

  always_comb begin
    o_block = i_block;
    for (int i = 0; i < MAX_RATE_BYTES; i++) begin
      if (w_mask[i]) o_block[i*8 +: 8] = w_src[i*8 +: 8];
    end
  end
endmodule

// File: rtl/absorb_unit.sv
// Packs a byte stream into rate blocks, applies pad10*1 with the mode suffix, hands blocks off.
// Optional keep-field checking (err_o) is built when ABSORB_KEEP_CHECK_EN is defined.
module absorb_unit
  import keccak_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [MODE_SEL_WIDTH-1:0] keccak_mode_i,
  input  logic [RATE_WIDTH-1:0]     rate_i,
  absorb_unit_if.slave              bus,
  output logic                      busy_o,
  output logic                      err_o
);
  localparam int BLK_W = MAX_RATE_BYTES * 8;

  absorb_state_e         r_state, w_state_nxt;
  keccak_mode_e          r_mode;
  logic [FILL_WIDTH-1:0] r_rate_b, r_fill, w_fill_new, w_rem_buf;
  logic [BOFF_WIDTH-1:0] r_beat_off, w_beat_n, w_rem_beat, w_n;
  logic                  r_pad_pending, r_last;
  logic                  w_fits, w_t_ready, w_block_valid;
  logic [BLK_W-1:0]      r_blk, w_packed, w_padded;
  logic                  w_unused_rate;

  assign w_unused_rate = ^rate_i[2:0];

  assign w_beat_n   = keep_popcount(bus.t_keep_i);
  assign w_rem_beat = (w_beat_n > r_beat_off) ? (w_beat_n - r_beat_off) : '0;
  assign w_rem_buf  = r_rate_b - r_fill;
  assign w_fits     = ({{(FILL_WIDTH-BOFF_WIDTH){1'b0}}, w_rem_beat} <= w_rem_buf);
  // When the beat does not fit, the shortfall is below one beat so it fits BOFF_WIDTH.
  assign w_n        = w_fits ? w_rem_beat : w_rem_buf[BOFF_WIDTH-1:0];
  assign w_fill_new = r_fill + {{(FILL_WIDTH-BOFF_WIDTH){1'b0}}, w_n};

  byte_packer u_packer (
    .i_block    (r_blk),
    .i_data     (bus.t_data_i),
    .i_beat_off (r_beat_off),
    .i_fill     (r_fill),
    .i_n        (w_n),
    .o_block    (w_packed)
  );

  always_comb begin
    w_padded = r_blk;
    for (int i = 0; i < MAX_RATE_BYTES; i++) begin
      if (FILL_WIDTH'(i) == r_fill)
        w_padded[i*8 +: 8] = w_padded[i*8 +: 8] ^ domain_suffix(r_mode);
      if (FILL_WIDTH'(i) == r_rate_b - FILL_WIDTH'(1))
        w_padded[i*8 +: 8] = w_padded[i*8 +: 8] ^ PAD_END;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_t_ready     = 1'b0;
    w_block_valid = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i) w_state_nxt = ABSORB;
      end
      ABSORB: begin
        w_t_ready = bus.t_valid_i && w_fits;
        if (bus.t_valid_i) begin
          if (w_fill_new == r_rate_b)        w_state_nxt = FLUSH;
          else if (w_fits && bus.t_last_i)   w_state_nxt = PAD;
        end
      end
      PAD: w_state_nxt = FLUSH;
      FLUSH: begin
        w_block_valid = 1'b1;
        if (bus.block_ready_i) begin
          if (r_last)             w_state_nxt = IDLE;
          else if (r_pad_pending) w_state_nxt = PAD;
          else                    w_state_nxt = ABSORB;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mode        <= SHA3_256;
      r_rate_b      <= '0;
      r_fill        <= '0;
      r_beat_off    <= '0;
      r_pad_pending <= 1'b0;
      r_last        <= 1'b0;
      r_blk         <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_mode        <= keccak_mode_e'(keccak_mode_i);
            r_rate_b      <= rate_i[RATE_WIDTH-1:3];
            r_fill        <= '0;
            r_beat_off    <= '0;
            r_pad_pending <= 1'b0;
            r_last        <= 1'b0;
            r_blk         <= '0;
          end
        end
        ABSORB: begin
          if (bus.t_valid_i) begin
            r_blk      <= w_packed;
            r_fill     <= w_fill_new;
            r_beat_off <= w_fits ? '0 : (r_beat_off + w_n);
            // An exactly-full final block still owes a separate pad-only block.
            if (w_fill_new == r_rate_b) r_pad_pending <= w_fits && bus.t_last_i;
          end
        end
        PAD: begin
          r_blk  <= w_padded;
          r_last <= 1'b1;
        end
        FLUSH: begin
          if (bus.block_ready_i) begin
            r_blk  <= '0;
            r_fill <= '0;
            if (r_last)             r_last        <= 1'b0;
            else if (r_pad_pending) r_pad_pending <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.t_ready_o     = w_t_ready;
  assign bus.block_valid_o = w_block_valid;
  assign bus.block_o       = r_blk;
  assign bus.block_last_o  = (r_state == FLUSH) && r_last;
  assign busy_o            = (r_state != IDLE);

`ifdef ABSORB_KEEP_CHECK_EN
  logic r_err, w_keep_bad;

  // Keep must be a run of ones from bit 0, and only the last beat may be partial.
  assign w_keep_bad = ((bus.t_keep_i & (bus.t_keep_i + KEEP_WIDTH'(1))) != '0) ||
                      (!bus.t_last_i && (bus.t_keep_i != '1));

  always_ff @(posedge clk_i) begin
    if (rst_i)                                              r_err <= 1'b0;
    else if (r_state == IDLE && start_i)                    r_err <= 1'b0;
    else if (r_state == ABSORB && bus.t_valid_i && w_keep_bad) r_err <= 1'b1;
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_absorb_unit.sv
// Scoreboard bench for absorb_unit: directed messages, expected blocks queued, monitor compares.
module tb_absorb_unit;
  import keccak_pkg::*;

  localparam int BW = MAX_RATE_BYTES * 8;

  typedef struct {
    logic [BW-1:0] blk;
    logic          last;
    int            lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [10:0] rate;
  logic        busy;
  logic        err;

  absorb_unit_if bus();

  absorb_unit dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .keccak_mode_i (mode),
    .rate_i        (rate),
    .bus           (bus),
    .busy_o        (busy),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  exp_t          sb_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  int            acc_cyc  = 0;
  logic [7:0]    msg[0:255];
  int            waits[0:15];
  logic [BW-1:0] e, e1;
  bit            seen = 0;
  int            first_cyc = 0;
  exp_t          pe;
  int            sw;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic check_blk(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    int idx;
    n_checks++;
    if (got !== exp) begin
      idx = 0;
      for (int i = MAX_RATE_BYTES - 1; i >= 0; i--)
        if (got[i*8 +: 8] !== exp[i*8 +: 8]) idx = i;
      n_fail++;
      $display("FAIL %s: first bad byte %0d got %02h, expected %02h", name, idx,
               got[idx*8 +: 8], exp[idx*8 +: 8]);
    end
  endtask

  task automatic push_exp(input logic [BW-1:0] blk, input logic last, input int lat);
    exp_t x;
    x.blk = blk; x.last = last; x.lat = lat;
    sb_q.push_back(x);
  endtask

  // Monitor: every block handshake pops one expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) seen = 0;
      else begin
        if (bus.block_valid_o && !seen) begin
          seen = 1;
          first_cyc = cyc;
        end
        if (bus.block_valid_o && bus.block_ready_i) begin
          seen = 0;
          if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_block: got a block, expected none");
          end else begin
            pe = sb_q.pop_front();
            check_blk("block_data", bus.block_o, pe.blk);
            check("block_last", {63'd0, bus.block_last_o}, {63'd0, pe.last});
            if (pe.lat >= 0) check("pad_latency", 64'(first_cyc - acc_cyc), 64'(pe.lat));
          end
        end
      end
    end
  end

  // All driving tasks start and end at posedge+1.
  task automatic send_beat(input logic [255:0] d, input logic [31:0] k, input logic l, output int w);
    bus.t_data_i  = d;
    bus.t_keep_i  = k;
    bus.t_last_i  = l;
    bus.t_valid_i = 1'b1;
    w = 0;
    @(negedge clk);
    while (!bus.t_ready_o && w < 300) begin
      w++;
      @(negedge clk);
    end
    if (w >= 300) begin
      n_checks++;
      n_fail++;
      $display("FAIL beat_accept: got no t_ready in %0d cycles, expected acceptance", w);
    end
    if (l) acc_cyc = cyc;
    @(posedge clk); #1;
    bus.t_valid_i = 1'b0;
    bus.t_last_i  = 1'b0;
  endtask

  task automatic start_msg(input logic [1:0] m, input logic [10:0] r);
    mode  = m;
    rate  = r;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_msg(input logic [1:0] m, input logic [10:0] r, input int nbytes);
    int nbeats, w;
    logic [255:0] d;
    logic [31:0]  kp;
    start_msg(m, r);
    nbeats = (nbytes == 0) ? 1 : (nbytes + 31) / 32;
    for (int b = 0; b < nbeats; b++) begin
      d = '0;
      kp = '0;
      for (int k = 0; k < 32; k++) begin
        if (b * 32 + k < nbytes) begin
          d[k*8 +: 8] = msg[b*32 + k];
          kp[k] = 1'b1;
        end
      end
      send_beat(d, kp, (b == nbeats - 1), w);
      waits[b] = w;
    end
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while ((sb_q.size() != 0 || busy) && w < 400) begin
      @(posedge clk); #1;
      w++;
    end
    check("drain_done", {63'd0, (w < 400)}, 64'd1);
  endtask

  task automatic build_160(output logic [BW-1:0] b1, output logic [BW-1:0] b2);
    b1 = '0;
    for (int i = 0; i < 136; i++) b1[i*8 +: 8] = msg[i];
    b2 = '0;
    for (int i = 0; i < 24; i++) b2[i*8 +: 8] = msg[136 + i];
    b2[24*8 +: 8]  = 8'h06;
    b2[135*8 +: 8] = 8'h80;
  endtask

  initial begin
    logic [255:0] d;
    int w;
    rst = 1'b1; start = 1'b0; mode = '0; rate = '0;
    bus.t_valid_i = 1'b0; bus.t_data_i = '0; bus.t_keep_i = '0; bus.t_last_i = 1'b0;
    bus.block_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_t_ready", {63'd0, bus.t_ready_o}, 64'd0);
    check("rst_block_valid", {63'd0, bus.block_valid_o}, 64'd0);
    check("rst_block_last", {63'd0, bus.block_last_o}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check_blk("rst_block_data", bus.block_o, '0);
    @(posedge clk); #1;

    // SHA3-256, 160 bytes: full block then padded tail with a straddled beat.
    for (int k = 0; k < 256; k++) msg[k] = 8'(k);
    build_160(e1, e);
    push_exp(e1, 1'b0, -1);
    push_exp(e, 1'b1, 2);
    send_msg(SHA3_256, 11'd1088, 160);
    check("beat4_wait", 64'(waits[3]), 64'd0);
    check("beat5_straddle_wait", 64'(waits[4]), 64'd2);
    wait_drain();

    // SHAKE128 empty message.
    e = '0;
    e[7:0] = 8'h1F;
    e[167*8 +: 8] = 8'h80;
    push_exp(e, 1'b1, 2);
    send_msg(SHAKE128, 11'd1344, 0);
    wait_drain();

    // SHA3-512, exactly one rate of data: full block then a pad-only block.
    for (int k = 0; k < 256; k++) msg[k] = 8'hC0 ^ 8'(k);
    e = '0;
    for (int i = 0; i < 72; i++) e[i*8 +: 8] = msg[i];
    push_exp(e, 1'b0, -1);
    e = '0;
    e[7:0] = 8'h06;
    e[71*8 +: 8] = 8'h80;
    push_exp(e, 1'b1, -1);
    send_msg(SHA3_512, 11'd576, 72);
    wait_drain();

    // SHA3-256, rate-1 bytes: suffix and end marker merge into 0x86.
    for (int k = 0; k < 256; k++) msg[k] = 8'(k * 3 + 1);
    e = '0;
    for (int i = 0; i < 135; i++) e[i*8 +: 8] = msg[i];
    e[135*8 +: 8] = 8'h86;
    push_exp(e, 1'b1, 2);
    send_msg(SHA3_256, 11'd1088, 135);
    wait_drain();
    check("err_wellformed", {63'd0, err}, 64'd0);

    // Core back-pressure for 10 cycles while a beat is held.
    for (int k = 0; k < 256; k++) msg[k] = ~8'(k);
    build_160(e1, e);
    push_exp(e1, 1'b0, -1);
    push_exp(e, 1'b1, 2);
    bus.block_ready_i = 1'b0;
    fork
      send_msg(SHA3_256, 11'd1088, 160);
      begin
        sw = 0;
        @(negedge clk);
        while (!bus.block_valid_o && sw < 300) begin
          sw++;
          @(negedge clk);
        end
        check("stall_reached", {63'd0, (sw < 300)}, 64'd1);
        repeat (10) begin
          check("stall_valid", {63'd0, bus.block_valid_o}, 64'd1);
          check("stall_t_ready", {63'd0, bus.t_ready_o}, 64'd0);
          check_blk("stall_data", bus.block_o, e1);
          @(negedge clk);
        end
        @(posedge clk); #1;
        bus.block_ready_i = 1'b1;
      end
    join
    wait_drain();

    // Reset after 40 bytes absorbed, then a fresh 3-byte message.
    start_msg(SHA3_256, 11'd1088);
    d = {32{8'hEE}};
    send_beat(d, 32'hFFFF_FFFF, 1'b0, w);
    d = {32{8'h5C}};
    send_beat(d, 32'h0000_00FF, 1'b0, w);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_block_valid", {63'd0, bus.block_valid_o}, 64'd0);
    check("midrst_t_ready", {63'd0, bus.t_ready_o}, 64'd0);
    check("midrst_err", {63'd0, err}, 64'd0);
    check_blk("midrst_block_data", bus.block_o, '0);
    @(posedge clk); #1;
    msg[0] = 8'hA1; msg[1] = 8'hA2; msg[2] = 8'hA3;
    e = '0;
    e[7:0] = 8'hA1; e[15:8] = 8'hA2; e[23:16] = 8'hA3;
    e[31:24] = 8'h06;
    e[135*8 +: 8] = 8'h80;
    push_exp(e, 1'b1, 2);
    send_msg(SHA3_256, 11'd1088, 3);
    wait_drain();

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    check("err_final", {63'd0, err}, 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
